// File: rtl/qlm_pkg.sv
// rtl/qlm_pkg.sv - shared widths and operand/product types for the QLM multiplier slice
package qlm_pkg;
  localparam int QLM_W  = 16;
  localparam int QLM_PW = 32;

  typedef struct packed {
    logic [QLM_W-1:0] x;
    logic [QLM_W-1:0] y;
  } qlm_ops_t;

  typedef logic [QLM_PW-1:0] qlm_prod_t;
endpackage

// File: rtl/QLM_w4q2.sv
// rtl/QLM_w4q2.sv - combinational log-domain approximate 16x16 multiplier
// Mitchell-style: leading-one exponents add, mantissas truncated to 4 fraction bits.
module QLM_w4q2
  import qlm_pkg::*;
(
  input  logic [QLM_W-1:0]  x,
  input  logic [QLM_W-1:0]  y,
  output logic [QLM_PW-1:0] p
);

  function automatic logic [3:0] lead_one(input logic [QLM_W-1:0] v);
    logic [3:0] k;
    k = '0;
    for (int i = 0; i < QLM_W; i++) begin
      if (v[i]) k = 4'(i);
    end
    return k;
  endfunction

  logic [3:0] kx, ky, fx, fy;
  logic [4:0] fsum, sh;
  logic [4:0] mant;

  always_comb begin
    kx   = lead_one(x);
    ky   = lead_one(y);
    fx   = 4'({x, 4'b0000} >> kx);
    fy   = 4'({y, 4'b0000} >> ky);
    fsum = {1'b0, fx} + {1'b0, fy};
    // A mantissa-sum carry moves one bit into the exponent; the leading 1 is always restored.
    sh   = {1'b0, kx} + {1'b0, ky} + {4'b0000, fsum[4]};
    mant = {1'b1, fsum[3:0]};
    if (x == '0 || y == '0) p = '0;
    else                    p = 32'(({31'b0, mant} << sh) >> 4);
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant, search starts at ptr and wraps
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/qlm_mult_arbiter.sv
// rtl/qlm_mult_arbiter.sv - round-robin sharing of one QLM_w4q2 multiplier, 2-stage pipeline
module qlm_mult_arbiter
  import qlm_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int TAG_W = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [16*N_REQ-1:0]    req_x,
  input  logic [16*N_REQ-1:0]    req_y,
  input  logic [TAG_W*N_REQ-1:0] req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_p,
  output logic [ID_W-1:0]        rsp_id,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   busy
);

  typedef struct packed {
    qlm_ops_t          ops;
    logic [ID_W-1:0]   id;
    logic [TAG_W-1:0]  tag;
  } s1_t;

  typedef struct packed {
    qlm_prod_t         p;
    logic [ID_W-1:0]   id;
    logic [TAG_W-1:0]  tag;
  } s2_t;

  s1_t             s1, s1_next;
  s2_t             s2;
  logic            s1_valid;
  logic [ID_W-1:0] rr_ptr, gnt_idx, next_ptr;
  logic [N_REQ-1:0] gnt;
  logic            adv1, adv2, accept;
  qlm_prod_t       prod;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  QLM_w4q2 u_mult (
    .x (s1.ops.x),
    .y (s1.ops.y),
    .p (prod)
  );

  assign adv2      = !rsp_valid || rsp_ready;
  assign adv1      = !s1_valid || adv2;
  assign req_ready = gnt & {N_REQ{adv1 && rst_n}};
  assign accept    = |req_ready;
  assign next_ptr  = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    s1_next       = '0;
    s1_next.ops.x = req_x[QLM_W*gnt_idx +: QLM_W];
    s1_next.ops.y = req_y[QLM_W*gnt_idx +: QLM_W];
    s1_next.id    = gnt_idx;
    s1_next.tag   = req_tag[TAG_W*gnt_idx +: TAG_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      s1_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      if (adv2) begin
        s2.p      <= prod;
        s2.id     <= s1.id;
        s2.tag    <= s1.tag;
        rsp_valid <= s1_valid;
      end
      if (adv1) begin
        s1       <= s1_next;
        s1_valid <= accept;
        if (accept) rr_ptr <= next_ptr;
      end
    end
  end

  assign rsp_p   = s2.p;
  assign rsp_id  = s2.id;
  assign rsp_tag = s2.tag;
  assign busy    = s1_valid || rsp_valid;

endmodule
